// File: rtl/vlg_echo_meas.sv
// Ultrasonic ranging front end: fires a periodic trigger pulse and measures the
// returned echo width in microseconds, reporting 16'hFFFF on a missing or stuck echo.
module vlg_echo_meas #(
    parameter int CLK_DIV    = 100,
    parameter int TRIG_US    = 10,
    parameter int TIMEOUT_US = 30000,
    parameter int PERIOD_US  = 60000
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_en,
    input  logic        i_echo,
    output logic        o_trig,
    output logic [15:0] o_t_us,
    output logic        o_valid,
    output logic        o_timeout
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int PRD_W = (PERIOD_US > 1) ? $clog2(PERIOD_US) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [PRD_W-1:0] PRD_LAST  = PRD_W'(PERIOD_US - 1);
    localparam logic [15:0]      TRIG_LAST = 16'(TRIG_US - 1);
    localparam logic [15:0]      TO_LAST   = 16'(TIMEOUT_US - 1);
    localparam logic [15:0]      TO_US     = 16'(TIMEOUT_US);

    typedef enum logic [2:0] {
        IDLE,
        TRIG,
        WAIT_RISE,
        MEAS,
        DONE_OK,
        DONE_TO
    } state_t;

    state_t state;
    state_t state_nxt;

    logic             echo_m;
    logic             echo_s;
    logic             echo_d;
    logic             rise;
    logic             fall;
    logic [DIV_W-1:0] div_cnt;
    logic             tick;
    logic [PRD_W-1:0] prd_cnt;
    logic             prd_start;
    logic [15:0]      step_cnt;
    logic [DIV_W-1:0] meas_cyc;
    logic             meas_wrap;
    logic [15:0]      us_cnt;
    logic [15:0]      us_nxt;

    // Two-flop synchronizer plus one delay flop for edge detection.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            echo_m <= 1'b0;
            echo_s <= 1'b0;
            echo_d <= 1'b0;
        end else begin
            echo_m <= i_echo;
            echo_s <= echo_m;
            echo_d <= echo_s;
        end
    end

    assign rise = echo_s & ~echo_d;
    assign fall = ~echo_s & echo_d;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            div_cnt <= '0;
        end else if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    assign tick = (div_cnt == DIV_LAST);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            prd_cnt <= '0;
        end else if (tick) begin
            prd_cnt <= (prd_cnt == PRD_LAST) ? '0 : prd_cnt + 1'b1;
        end
    end

    assign prd_start = tick && (prd_cnt == PRD_LAST);

    // Width counting includes the wrap of the cycle in which the fall is seen,
    // so the reported value is floor(high cycles / CLK_DIV).
    assign meas_wrap = (meas_cyc == DIV_LAST);
    assign us_nxt    = us_cnt + {15'd0, meas_wrap};

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (prd_start && i_en) begin
                    state_nxt = TRIG;
                end
            end
            TRIG: begin
                if (tick && (step_cnt == TRIG_LAST)) begin
                    state_nxt = WAIT_RISE;
                end
            end
            WAIT_RISE: begin
                if (rise) begin
                    state_nxt = MEAS;
                end else if (tick && (step_cnt == TO_LAST)) begin
                    state_nxt = DONE_TO;
                end
            end
            MEAS: begin
                // A fall coinciding with reaching the limit is still a timeout.
                if (us_nxt >= TO_US) begin
                    state_nxt = DONE_TO;
                end else if (fall) begin
                    state_nxt = DONE_OK;
                end
            end
            DONE_OK: state_nxt = IDLE;
            DONE_TO: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Tick counter for the trigger width and the echo-rise timeout.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            step_cnt <= '0;
        end else if (state_nxt != state) begin
            step_cnt <= '0;
        end else if (tick && ((state == TRIG) || (state == WAIT_RISE))) begin
            step_cnt <= step_cnt + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            meas_cyc <= '0;
            us_cnt   <= '0;
        end else if ((state == WAIT_RISE) && rise) begin
            meas_cyc <= '0;
            us_cnt   <= '0;
        end else if (state == MEAS) begin
            meas_cyc <= meas_wrap ? '0 : meas_cyc + 1'b1;
            us_cnt   <= us_nxt;
        end
    end

    // Results are loaded on the edge that enters a DONE state so they line up with o_valid.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            o_t_us    <= '0;
            o_timeout <= 1'b0;
        end else if (state_nxt == DONE_OK) begin
            o_t_us    <= us_nxt;
            o_timeout <= 1'b0;
        end else if (state_nxt == DONE_TO) begin
            o_t_us    <= 16'hFFFF;
            o_timeout <= 1'b1;
        end
    end

    assign o_trig  = (state == TRIG);
    assign o_valid = (state == DONE_OK) || (state == DONE_TO);

endmodule

// File: tb/tb_vlg_echo_meas.sv
// Directed self-checking bench for vlg_echo_meas with a 4-cycle microsecond and
// a 300 us period, so one period is 1200 clock cycles.
module tb_vlg_echo_meas;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic        echo;
    logic        trig;
    logic [15:0] t_us;
    logic        valid;
    logic        timeout;

    int testCount = 0;
    int failCount = 0;

    vlg_echo_meas #(
        .CLK_DIV   (4),
        .TRIG_US   (10),
        .TIMEOUT_US(100),
        .PERIOD_US (300)
    ) dut (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
        .i_en     (en),
        .i_echo   (echo),
        .o_trig   (trig),
        .o_t_us   (t_us),
        .o_valid  (valid),
        .o_timeout(timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        testCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)",
                     tag, observed, observed, expected, expected);
        end
    endtask

    task automatic applyStimulus(input logic level, input int cycles);
        echo = level;
        repeat (cycles) @(negedge clk);
    endtask

    // Waits for the trigger, optionally raises echo as soon as it is seen,
    // and returns in the first cycle after the trigger falls.
    task automatic catchTrigger(input string tag, input logic echoOnRise);
        int n;
        n = 0;
        while (trig !== 1'b1 && n < 1300) begin
            @(negedge clk);
            n++;
        end
        checkOutput({tag, "_trig_seen"}, {31'd0, trig}, 32'd1);
        echo = echoOnRise;
        n = 0;
        while (trig === 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        checkOutput({tag, "_trig_width"}, n, 32'd40);
    endtask

    task automatic waitValid(input string tag, input int limit, output int n);
        n = 0;
        while (valid !== 1'b1 && n < limit) begin
            @(negedge clk);
            n++;
        end
        checkOutput({tag, "_strobe"}, {31'd0, valid}, 32'd1);
    endtask

    initial begin
        int n;
        int stray;

        rst_n = 1'b0;
        en    = 1'b1;
        echo  = 1'b0;
        repeat (5) @(negedge clk);
        checkOutput("reset_trig", {31'd0, trig}, 32'd0);
        checkOutput("reset_t_us", {16'd0, t_us}, 32'd0);
        checkOutput("reset_valid", {31'd0, valid}, 32'd0);
        checkOutput("reset_timeout", {31'd0, timeout}, 32'd0);

        rst_n = 1'b1;
        n = 0;
        while (trig !== 1'b1 && n < 1300) begin
            @(negedge clk);
            n++;
        end
        checkOutput("first_trig_delay", n, 32'd1200);

        // Normal echo: 233 high cycles -> floor(233/4) = 58
        catchTrigger("normal", 1'b0);
        applyStimulus(1'b0, 20);
        applyStimulus(1'b1, 233);
        echo = 1'b0;
        waitValid("normal", 600, n);
        checkOutput("normal_latency", n, 32'd3);
        checkOutput("normal_t_us", {16'd0, t_us}, 32'd58);
        checkOutput("normal_timeout", {31'd0, timeout}, 32'd0);
        @(negedge clk);
        checkOutput("normal_single_strobe", {31'd0, valid}, 32'd0);
        checkOutput("normal_hold", {16'd0, t_us}, 32'd58);

        // No echo: timeout 100 us after the trigger ends
        catchTrigger("noecho", 1'b0);
        waitValid("noecho", 600, n);
        checkOutput("noecho_latency_in_396_404", {31'd0, (n >= 396 && n <= 404)}, 32'd1);
        checkOutput("noecho_t_us", {16'd0, t_us}, 32'hFFFF);
        checkOutput("noecho_timeout", {31'd0, timeout}, 32'd1);

        // Stuck echo: rise 8 cycles after trigger ends, held 1000 cycles
        catchTrigger("stuck", 1'b0);
        applyStimulus(1'b0, 8);
        echo = 1'b1;
        waitValid("stuck", 600, n);
        checkOutput("stuck_latency_in_398_406", {31'd0, (n >= 398 && n <= 406)}, 32'd1);
        checkOutput("stuck_t_us", {16'd0, t_us}, 32'hFFFF);
        checkOutput("stuck_timeout", {31'd0, timeout}, 32'd1);
        stray = 0;
        for (int i = 0; i < 590; i++) begin
            @(negedge clk);
            if (valid === 1'b1) stray++;
        end
        echo = 1'b0;
        checkOutput("stuck_no_second_strobe", stray, 32'd0);

        // Pre-high echo: only the fresh 80-cycle pulse counts -> 20
        catchTrigger("prehigh", 1'b1);
        applyStimulus(1'b1, 30);
        applyStimulus(1'b0, 10);
        applyStimulus(1'b1, 80);
        echo = 1'b0;
        waitValid("prehigh", 600, n);
        checkOutput("prehigh_t_us", {16'd0, t_us}, 32'd20);
        checkOutput("prehigh_timeout", {31'd0, timeout}, 32'd0);

        // Longest width below the limit: 399 cycles -> 99
        catchTrigger("maxw", 1'b0);
        applyStimulus(1'b0, 5);
        applyStimulus(1'b1, 399);
        echo = 1'b0;
        waitValid("maxw", 600, n);
        checkOutput("maxw_t_us", {16'd0, t_us}, 32'd99);
        checkOutput("maxw_timeout", {31'd0, timeout}, 32'd0);

        // Reset pulse in the middle of a measurement
        catchTrigger("midrst", 1'b0);
        applyStimulus(1'b0, 10);
        applyStimulus(1'b1, 50);
        rst_n = 1'b0;
        applyStimulus(1'b0, 3);
        checkOutput("midrst_trig_low", {31'd0, trig}, 32'd0);
        rst_n = 1'b1;
        n = 0;
        stray = 0;
        while (trig !== 1'b1 && n < 1300) begin
            @(negedge clk);
            n++;
            if (valid === 1'b1) stray++;
        end
        checkOutput("midrst_no_strobe", stray, 32'd0);
        checkOutput("midrst_t_us", {16'd0, t_us}, 32'd0);
        checkOutput("midrst_timeout", {31'd0, timeout}, 32'd0);
        checkOutput("midrst_period_restart", n, 32'd1200);

        // Dropping enable during a trigger lets that measurement finish
        en = 1'b0;
        waitValid("disable_completes", 600, n);
        checkOutput("disable_completes_timeout", {31'd0, timeout}, 32'd1);
        stray = 0;
        for (int i = 0; i < 3600; i++) begin
            @(negedge clk);
            if (trig === 1'b1) stray++;
        end
        checkOutput("disable_no_trig", stray, 32'd0);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
